// File: rtl/wp_pkg.sv
// Shared types and constants for the panel push-button path.
// Test-plan constants let the bench build the top with the same values.
package wp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_CHK,
      PRESSED,
      REL_CHK
   } btn_state_t;

   localparam int DB_CYCLES_DEF     = 1_000_000;
   localparam int REPEAT_DELAY_DEF  = 50_000_000;
   localparam int REPEAT_PERIOD_DEF = 20_000_000;

   localparam int TP_DB_CYCLES     = 4;
   localparam int TP_REPEAT_DELAY  = 10;
   localparam int TP_REPEAT_PERIOD = 4;

   // Bits needed to hold values 0..n.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous panel inputs.
// Both stages reset to 0; q_o is the second stage.
import wp_pkg::*;

module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;

   // Metastability filter: sample, then resample.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Button conditioner: sync -> debounce FSM -> press/release pulses.
// Optional auto-repeat while held: define BTN_REPEAT_EN.
import wp_pkg::*;

module btn_debounce_pulse #(
   parameter int DB_CYCLES     = DB_CYCLES_DEF,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int CW = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic btn_sync;

   btn_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic level_q, level_d;
   logic press_q, press_d;
   logic rel_q, rel_d;
   logic enter_pressed;
   logic stay_pressed;
   logic rep_fire;

   sync_2ff #(
      .W(1)
   ) u_sync (
      .clk_i (clk),
      .rst_ni(rst_n),
      .d_i   (btn_raw),
      .q_o   (btn_sync)
   );

   // Debounce next-state: a transition is accepted only after
   // DB_CYCLES consecutive samples at the new level.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      level_d       = level_q;
      press_d       = 1'b0;
      rel_d         = 1'b0;
      enter_pressed = 1'b0;
      stay_pressed  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (btn_sync) begin
               state_d = PRESS_CHK;
               cnt_d   = '0;
            end
         end
         PRESS_CHK: begin
            if (!btn_sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d       = PRESSED;
               cnt_d         = '0;
               level_d       = 1'b1;
               press_d       = 1'b1;
               enter_pressed = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_sync) begin
               state_d = REL_CHK;
               cnt_d   = '0;
            end else begin
               stay_pressed = 1'b1;
            end
         end
         REL_CHK: begin
            if (btn_sync) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Debounce state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d | rep_fire;
         rel_q   <= rel_d;
      end
   end

`ifdef BTN_REPEAT_EN
   localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] rep_q, rep_d;
   logic first_q, first_d;

   // Repeat timer: counts only while held in PRESSED, holds in
   // REL_CHK, and restarts on every fresh accepted press.
   always_comb begin
      rep_d    = rep_q;
      first_d  = first_q;
      rep_fire = 1'b0;
      if (enter_pressed) begin
         rep_d   = '0;
         first_d = 1'b1;
      end else if (stay_pressed) begin
         if (rep_q == (first_q ? DLY_LAST : PER_LAST)) begin
            rep_fire = 1'b1;
            rep_d    = '0;
            first_d  = 1'b0;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
   end

   // Repeat timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q   <= '0;
         first_q <= 1'b0;
      end else begin
         rep_q   <= rep_d;
         first_q <= first_d;
      end
   end
`else
   logic unused_rep;

   assign rep_fire   = 1'b0;
   assign unused_rep = ^{enter_pressed, stay_pressed,
                         32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = rel_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with the test-plan constants.
// Edge k of a run is the k-th posedge after the run starts.
import wp_pkg::*;

module tb_btn_debounce_pulse;

`ifdef BTN_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic btn_raw;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;

   logic [63:0] pv;
   logic [63:0] rv;
   logic [63:0] lv;

   int n_run;
   int n_fail;

   btn_debounce_pulse #(
      .DB_CYCLES    (TP_DB_CYCLES),
      .REPEAT_DELAY (TP_REPEAT_DELAY),
      .REPEAT_PERIOD(TP_REPEAT_PERIOD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_raw      (btn_raw),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] m(input int lo, input int hi);
      logic [63:0] r;
      r = '0;
      for (int i = lo; i <= hi; i++) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [63:0] b(input int k);
      return m(k, k);
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // pat[k] is the btn_raw value sampled on edge k.
   task automatic run(input int n, input logic [63:0] pat);
      pv = '0;
      rv = '0;
      lv = '0;
      for (int k = 1; k <= n; k++) begin
         btn_raw = pat[k];
         @(posedge clk);
         #1;
         pv[k] = press_pulse;
         rv[k] = release_pulse;
         lv[k] = btn_level;
      end
   endtask

   task automatic chk_run(input string t, input logic [63:0] ep,
                          input logic [63:0] er, input logic [63:0] el);
      chk({t, "_press"}, pv, ep);
      chk({t, "_release"}, rv, er);
      chk({t, "_level"}, lv, el);
   endtask

   function automatic logic [63:0] outs();
      return 64'({btn_level, press_pulse, release_pulse});
   endfunction

   initial begin
      n_run   = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      btn_raw = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", outs(), 64'd0);
      rst_n = 1'b1;

      run(20, m(1, 20));
      chk_run("clean", b(7) | (REP ? b(17) : 64'd0), 64'd0, m(7, 20));

      run(20, 64'd0);
      chk_run("release", REP ? b(1) : 64'd0, b(7), m(1, 6));

      run(14, m(1, 2) | m(4, 14));
      chk_run("bounce", b(10), 64'd0, m(10, 14));

      run(8, m(3, 8));
      chk_run("rel_bounce", 64'd0, 64'd0, m(1, 8));

      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_pressed", outs(), 64'd0);
      btn_raw = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run(5, m(1, 5));
      chk_run("pchk", 64'd0, 64'd0, 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_pchk", outs(), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run(7, m(1, 7));
      chk_run("rst_held", b(7), 64'd0, b(7));
      #2;
      chk("pulse_live", 64'(press_pulse), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_pulse", outs(), 64'd0);
      btn_raw = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run(34, m(1, 34));
      chk_run("repeat",
              b(7) | (REP ? (b(17) | b(21) | b(25) | b(29) | b(33))
                          : 64'd0),
              64'd0, m(7, 34));

      run(10, 64'd0);
      chk_run("rep_release", 64'd0, b(7), m(1, 6));

      run(32, m(1, 18));
      chk_run("rep_cancel", b(7) | (REP ? b(17) : 64'd0), b(25),
              m(7, 24));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
